// File: rtl/subtractor_2stage_buf.sv
// 2-stage pipelined unsigned subtractor, out_diff = {1'b0,in_a} - {1'b0,in_b}; optional clamp via SUB_SATURATE_EN.
// Latency 2 cycles from input transfer to out_valid; 1 result per cycle when out_ready is held high.
// Backpressure: stages advance only into an empty or draining slot; in_ready drops once both stages are full.
module subtractor_2stage_buf #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_diff
);

  localparam int HI_W = WIDTH - SPLIT;

  logic             s1_valid;
  logic [SPLIT-1:0] s1_lo;
  logic             s1_borrow;
  logic [HI_W-1:0]  s1_a_hi;
  logic [HI_W-1:0]  s1_b_hi;

  logic             s1_load;
  logic             s2_load;
  logic [SPLIT:0]   lo_full;
  logic [HI_W:0]    hi_full;
  logic [WIDTH:0]   result;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Extra top bit of each slice captures the borrow out of that slice.
  assign lo_full = {1'b0, in_a[SPLIT-1:0]} - {1'b0, in_b[SPLIT-1:0]};
  assign hi_full = {1'b0, s1_a_hi} - {1'b0, s1_b_hi} - {{HI_W{1'b0}}, s1_borrow};

  always_comb begin
`ifdef SUB_SATURATE_EN
    result = hi_full[HI_W] ? '0 : {hi_full, s1_lo};
`else
    result = {hi_full, s1_lo};
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_lo     <= '0;
      s1_borrow <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
      out_valid <= 1'b0;
      out_diff  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
      end
      if (s1_load && in_valid) begin
        s1_lo     <= lo_full[SPLIT-1:0];
        s1_borrow <= lo_full[SPLIT];
        s1_a_hi   <= in_a[WIDTH-1:SPLIT];
        s1_b_hi   <= in_b[WIDTH-1:SPLIT];
      end
      // A bubble clears out_valid but leaves out_diff at its last value.
      if (s2_load) begin
        out_valid <= s1_valid;
      end
      if (s2_load && s1_valid) begin
        out_diff <= result;
      end
    end
  end

endmodule

// File: tb/tb_subtractor_2stage_buf.sv
// Scoreboard bench for subtractor_2stage_buf: driver pushes expected results, negedge monitor pops and compares.
module tb_subtractor_2stage_buf;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [32:0] out_diff;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  subtractor_2stage_buf #(.WIDTH(32), .SPLIT(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_diff (out_diff)
  );

  always #5 clock = ~clock;

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    d = {1'b0, a} - {1'b0, b};
`ifdef SUB_SATURATE_EN
    if (d[32]) d = '0;
`endif
    return d;
  endfunction

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: an output transfer happens at the next posedge whenever out_valid && out_ready here.
  always @(negedge clock) begin
    if (!reset && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", out_diff);
      end else begin
        chk("scoreboard", out_diff, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the input transfer edge, in_valid left high.
  task automatic send_exp(input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp);
    int n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    n = 0;
    forever begin
      @(negedge clock);
      if (in_ready) begin
        exp_q.push_back(exp);
        @(posedge clock);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        chk("send_timeout", 33'(n), 33'd0);
        break;
      end
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    send_exp(a, b, model(a, b));
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_empty", 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    logic [32:0] first_exp;
    #1 reset = 1'b1;
    #1;
    chk("reset_out_valid", 33'(out_valid), 33'd0);
    chk("reset_out_diff", out_diff, 33'd0);
    chk("reset_in_ready", 33'(in_ready), 33'd1);
    #20 reset = 1'b0;
    @(posedge clock);
    #1;

    // Latency: result visible at the second negedge after the transfer edge.
    send_exp(32'd9273, 32'd3827, 33'h0_0000_1546);
    in_valid = 1'b0;
    @(negedge clock);
    chk("latency_s1_only", 33'(out_valid), 33'd0);
    @(negedge clock);
    chk("latency_out_valid", 33'(out_valid), 33'd1);
    @(posedge clock);
    #1;

`ifdef SUB_SATURATE_EN
    send_exp(32'd0, 32'd9253, 33'h0_0000_0000);
`else
    send_exp(32'd0, 32'd9253, 33'h1_FFFF_DBDB);
`endif
    send_exp(32'h0001_0000, 32'h0000_0001, 33'h0_0000_FFFF);
    send_exp(32'hFFFF_FFFF, 32'h0000_0000, 33'h0_FFFF_FFFF);
`ifdef SUB_SATURATE_EN
    send_exp(32'h0000_0000, 32'h0000_0001, 33'h0_0000_0000);
`else
    send_exp(32'h0000_0000, 32'h0000_0001, 33'h1_FFFF_FFFF);
`endif
    send_exp(32'h1234_5678, 32'h1234_5678, 33'h0_0000_0000);
    idle(1);
    drain();

    // Stall: two accepts fill the pipe, then in_ready must fall and out_diff must hold.
    out_ready = 1'b0;
    first_exp = 33'h0_0000_0064;
    send_exp(32'd300, 32'd200, first_exp);
    send_exp(32'd1000, 32'd1, 33'h0_0000_03E7);
    in_a = 32'd5;
    in_b = 32'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_in_ready", 33'(in_ready), 33'd0);
      chk("stall_out_diff", out_diff, first_exp);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    fork
      begin
`ifdef SUB_SATURATE_EN
        send_exp(32'd5, 32'd7, 33'h0_0000_0000);
`else
        send_exp(32'd5, 32'd7, 33'h1_FFFF_FFFE);
`endif
        send_exp(32'hABCD_0000, 32'h0000_0001, 33'h0_ABCC_FFFF);
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clock);
          chk("release_back_to_back", 33'(out_valid), 33'd1);
        end
      end
    join
    drain();

    // Asynchronous reset mid-cycle with two results in flight.
    out_ready = 1'b0;
    send(32'd50, 32'd10);
    send(32'd60, 32'd20);
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("arst_out_valid", 33'(out_valid), 33'd0);
    chk("arst_out_diff", out_diff, 33'd0);
    chk("arst_in_ready", 33'(in_ready), 33'd1);
    exp_q.delete();
    #10 reset = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("no_stale_after_reset", 33'(out_valid), 33'd0);

    // Random in_valid gaps, out_ready high, 1000 pairs against the model.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      send($urandom(), $urandom());
    end
    idle(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
